// File: rtl/vend_machine_multi.sv
// Multi-product vending controller: credits 0.5/1.0 coins, vends one of
// N_ITEMS products at per-item prices, refunds change one coin per cycle.
module vend_machine_multi #(
  parameter int                          CREDIT_W   = 8,
  parameter int                          N_ITEMS    = 4,
  parameter int                          SEL_W      = 2,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICE_LIST = {8'd6, 8'd5, 8'd4, 8'd3},
  parameter int                          MAX_CREDIT = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  output logic                drink,
  output logic [SEL_W-1:0]    item,
  output logic [1:0]          back,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                err
);

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  localparam logic [CREDIT_W:0] MAX_EXT = MAX_CREDIT[CREDIT_W:0];

  state_t              state, state_nxt;
  logic [1:0]          coin_prev;
  logic [CREDIT_W-1:0] credit_nxt;
  logic                drink_nxt, err_nxt;
  logic [SEL_W-1:0]    item_nxt;
  logic [1:0]          back_nxt;

  logic                coin_edge, coin_bad, coin_ok, coin_refused;
  logic [CREDIT_W:0]   coin_val, credit_ext, coin_sum, credited, price_ext;
  logic                sel_in_range, sel_ok;
  logic [SEL_W-1:0]    sel_idx;
  logic [CREDIT_W-1:0] price_sel;

  assign busy = (state == S_VEND) || (state == S_CHANGE);

  // Coin edge detection, overflow guard and price lookup (CREDIT_W+1 bit math)
  always_comb begin
    coin_edge    = (coin != 2'b00) && (coin_prev == 2'b00);
    coin_bad     = coin_edge && (coin == 2'b11);
    coin_val     = '0;
    if (coin_edge && coin == 2'b01) coin_val = (CREDIT_W+1)'(1);
    if (coin_edge && coin == 2'b10) coin_val = (CREDIT_W+1)'(2);
    credit_ext   = {1'b0, credit};
    coin_sum     = credit_ext + coin_val;
    coin_ok      = (coin_val != '0) && (coin_sum <= MAX_EXT);
    coin_refused = (coin_val != '0) && !coin_ok;
    credited     = coin_ok ? coin_sum : credit_ext;
    sel_in_range = int'(sel) < N_ITEMS;
    sel_idx      = sel_in_range ? sel : '0;
    price_sel    = PRICE_LIST[int'(sel_idx)*CREDIT_W +: CREDIT_W];
    price_ext    = {1'b0, price_sel};
    sel_ok       = sel_in_range && (credit_ext >= price_ext);
  end

  // Next-state and registered-output values
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    drink_nxt  = 1'b0;
    item_nxt   = item;
    back_nxt   = 2'b00;
    err_nxt    = 1'b0;
    case (state)
      S_IDLE, S_CREDIT: begin
        if (coin_bad || coin_refused) err_nxt = 1'b1;
        if (coin_refused) back_nxt = coin;
        if (cancel) begin
          credit_nxt = CREDIT_W'(credited);
          state_nxt  = (credited != '0) ? S_CHANGE : S_IDLE;
        end else if (sel_valid && sel_ok) begin
          state_nxt  = S_VEND;
          drink_nxt  = 1'b1;
          item_nxt   = sel;
          credit_nxt = CREDIT_W'(credited - price_ext);
        end else begin
          if (sel_valid) err_nxt = 1'b1;
          credit_nxt = CREDIT_W'(credited);
          state_nxt  = (credited != '0) ? S_CREDIT : S_IDLE;
        end
      end
      S_VEND: state_nxt = (credit != '0) ? S_CHANGE : S_IDLE;
      S_CHANGE: begin
        // The last coin is presented while still in CHANGE; leave once empty
        if (credit >= CREDIT_W'(2)) begin
          back_nxt   = 2'b10;
          credit_nxt = credit - CREDIT_W'(2);
        end else if (credit == CREDIT_W'(1)) begin
          back_nxt   = 2'b01;
          credit_nxt = '0;
        end else begin
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any vend/refund in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      credit    <= '0;
      drink     <= 1'b0;
      item      <= '0;
      back      <= 2'b00;
      err       <= 1'b0;
      coin_prev <= 2'b00;
    end else begin
      state     <= state_nxt;
      credit    <= credit_nxt;
      drink     <= drink_nxt;
      item      <= item_nxt;
      back      <= back_nxt;
      err       <= err_nxt;
      coin_prev <= coin;
    end
  end

endmodule

// File: tb/tb_vend_machine_multi.sv
// Self-checking bench for vend_machine_multi: directed literal checks plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_vend_machine_multi;

  localparam int MAXC = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       sel_valid = 1'b0;
  logic [2:0] sel = 3'd0;
  logic       cancel = 1'b0;
  logic       drink;
  logic [2:0] item;
  logic [1:0] back;
  logic [7:0] credit;
  logic       busy;
  logic       err;

  int checks = 0;
  int failures = 0;

  vend_machine_multi #(
    .CREDIT_W(8), .N_ITEMS(4), .SEL_W(3),
    .PRICE_LIST({8'd6, 8'd5, 8'd4, 8'd3}), .MAX_CREDIT(MAXC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coin(coin), .sel_valid(sel_valid), .sel(sel),
    .cancel(cancel), .drink(drink), .item(item), .back(back), .credit(credit),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic       drink;
    logic [2:0] item;
    logic [1:0] back;
    int         credit;
    logic       busy;
    logic       err;
  } out_t;

  out_t       plan[$];
  out_t       exp_o;
  int         m_credit;
  logic [1:0] m_prev;
  logic [2:0] m_item;
  int         prices[4] = '{3, 4, 5, 6};

  function automatic out_t mk(logic d, logic [2:0] it, logic [1:0] b, int c,
                              logic bz, logic e);
    out_t o;
    o.drink = d; o.item = it; o.back = b; o.credit = c; o.busy = bz; o.err = e;
    return o;
  endfunction

  // Largest coin first, one per cycle, then one final idle cycle
  task automatic add_refund(input int r);
    int left;
    left = r;
    while (left > 0) begin
      if (left >= 2) begin left -= 2; plan.push_back(mk(0, m_item, 2'b10, left, 1, 0)); end
      else begin left -= 1; plan.push_back(mk(0, m_item, 2'b01, left, 1, 0)); end
    end
    plan.push_back(mk(0, m_item, 2'b00, 0, 0, 0));
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [1:0] c;
    logic       fresh, e;
    logic [1:0] echo;
    int         val, after, rem;
    if (!rst_n) begin
      plan.delete();
      m_credit = 0; m_prev = 2'b00; m_item = 3'd0;
      exp_o = mk(0, 0, 0, 0, 0, 0);
    end else begin
      c = coin;
      fresh = (c != 2'b00) && (m_prev == 2'b00);
      m_prev = c;
      if (plan.size() > 0) begin
        exp_o = plan.pop_front();
      end else begin
        val = !fresh ? 0 : (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
        e = fresh && (c == 2'b11);
        echo = 2'b00;
        after = m_credit;
        if (val > 0) begin
          if (m_credit + val > MAXC) begin e = 1; echo = c; end
          else after = m_credit + val;
        end
        if (cancel) begin
          if (after > 0) begin
            plan.push_back(mk(0, m_item, echo, after, 1, e));
            add_refund(after);
            after = 0;
          end
        end else if (sel_valid) begin
          if (int'(sel) >= 4 || m_credit < prices[sel[1:0]]) e = 1;
          else begin
            rem = after - prices[sel[1:0]];
            m_item = sel;
            plan.push_back(mk(1, sel, echo, rem, 1, e));
            if (rem > 0) plan.push_back(mk(0, sel, 2'b00, rem, 1, 0));
            add_refund(rem);
            after = 0;
          end
        end
        m_credit = after;
        if (plan.size() > 0) exp_o = plan.pop_front();
        else exp_o = mk(0, m_item, echo, after, 0, e);
      end
    end
  end

  // Compare process: outputs against the model once per cycle
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_drink", int'(drink), int'(exp_o.drink));
      if (exp_o.drink) chk("m_item", int'(item), int'(exp_o.item));
      chk("m_back", int'(back), int'(exp_o.back));
      chk("m_credit", int'(credit), exp_o.credit);
      chk("m_busy", int'(busy), int'(exp_o.busy));
      chk("m_err", int'(err), int'(exp_o.err));
    end
  end

  // Drive inputs at negedge, return at next negedge (outputs then reflect them)
  task automatic cyc(input logic [1:0] c, input logic sv, input logic [2:0] s,
                     input logic cn);
    coin = c; sel_valid = sv; sel = s; cancel = cn;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_back", int'(back), 0);
    rst_n = 1'b1;

    // 0.5 x3 then buy item 0 (price 3)
    cyc(2'b01, 0, 0, 0); chk("t1_c1", int'(credit), 1);
    cyc(2'b00, 0, 0, 0);
    cyc(2'b01, 0, 0, 0); chk("t1_c2", int'(credit), 2);
    cyc(2'b00, 0, 0, 0);
    cyc(2'b01, 0, 0, 0); chk("t1_c3", int'(credit), 3);
    cyc(2'b00, 1, 0, 0);
    chk("t1_drink", int'(drink), 1); chk("t1_item", int'(item), 0);
    chk("t1_credit", int'(credit), 0);
    cyc(2'b00, 0, 0, 0);
    chk("t1_drink_off", int'(drink), 0); chk("t1_idle", int'(busy), 0);

    // 1.0 x2, buy item 0, one 0.5 change coin
    cyc(2'b10, 0, 0, 0); cyc(2'b00, 0, 0, 0); cyc(2'b10, 0, 0, 0);
    chk("t2_c4", int'(credit), 4);
    cyc(2'b00, 1, 0, 0); chk("t2_drink", int'(drink), 1); chk("t2_rem", int'(credit), 1);
    cyc(2'b00, 0, 0, 0); chk("t2_back0", int'(back), 0);
    cyc(2'b00, 0, 0, 0); chk("t2_back01", int'(back), 1); chk("t2_c0", int'(credit), 0);
    cyc(2'b00, 0, 0, 0); chk("t2_back_end", int'(back), 0); chk("t2_busy", int'(busy), 0);

    // Held coin counts once; invalid coin
    repeat (5) cyc(2'b10, 0, 0, 0);
    chk("t3_hold", int'(credit), 2);
    cyc(2'b00, 0, 0, 0);
    cyc(2'b11, 0, 0, 0); chk("t3_err", int'(err), 1); chk("t3_c", int'(credit), 2);
    cyc(2'b00, 0, 0, 0); chk("t3_err_off", int'(err), 0);

    // Insufficient credit and out-of-range selection
    cyc(2'b00, 1, 3, 0); chk("t4_err", int'(err), 1); chk("t4_nodrink", int'(drink), 0);
    chk("t4_c", int'(credit), 2);
    cyc(2'b00, 1, 4, 0); chk("t4_range", int'(err), 1);

    // Credit 5, cancel -> 10,10,01; coins during refund ignored
    cyc(2'b10, 0, 0, 0); cyc(2'b00, 0, 0, 0); cyc(2'b01, 0, 0, 0); cyc(2'b00, 0, 0, 0);
    chk("t5_c5", int'(credit), 5);
    cyc(2'b00, 0, 0, 1); chk("t5_busy", int'(busy), 1);
    cyc(2'b10, 0, 0, 0); chk("t5_b1", int'(back), 2);
    cyc(2'b00, 0, 0, 0); chk("t5_b2", int'(back), 2);
    cyc(2'b01, 0, 0, 0); chk("t5_b3", int'(back), 1); chk("t5_busy3", int'(busy), 1);
    cyc(2'b00, 0, 0, 0); chk("t5_c0", int'(credit), 0); chk("t5_idle", int'(busy), 0);

    // Fill to MAX_CREDIT, refused coin echo
    repeat (10) begin cyc(2'b10, 0, 0, 0); cyc(2'b00, 0, 0, 0); end
    chk("t6_c20", int'(credit), 20);
    cyc(2'b01, 0, 0, 0);
    chk("t6_echo", int'(back), 1); chk("t6_err", int'(err), 1); chk("t6_c", int'(credit), 20);
    cyc(2'b00, 0, 0, 0); chk("t6_echo_off", int'(back), 0);

    // Async reset mid-refund
    cyc(2'b00, 0, 0, 1);
    cyc(2'b00, 0, 0, 0); chk("t7_b", int'(back), 2); chk("t7_c18", int'(credit), 18);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("t7_drink", int'(drink), 0); chk("t7_back", int'(back), 0);
    chk("t7_credit", int'(credit), 0); chk("t7_busy", int'(busy), 0);
    chk("t7_err", int'(err), 0); chk("t7_item", int'(item), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [1:0] c;
      r = int'($urandom_range(0, 9));
      c = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      if (i == 2000) begin
        @(posedge clk); #3 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end
      cyc(c, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
